// File: rtl/if_stage_prefetch.sv
`default_nettype none
// ============================================================================
// if_stage_prefetch : instruction fetch stage with handshaked memory port and
//                     prefetch queue; freeze stalls decode, branch flushes.
// Revision: 1.0
// ============================================================================
module if_stage_prefetch #(
    parameter int unsigned           BIT_NUMBER = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter int unsigned           PC_STEP    = 4,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_address,
    output logic                  mem_req,
    output logic [BIT_NUMBER-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [BIT_NUMBER-1:0] mem_rdata,
    output logic                  valid,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instruction
);

    localparam int unsigned           PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned           CNT_W   = PTR_W + 1;
    localparam logic [BIT_NUMBER-1:0] STEP    = BIT_NUMBER'(PC_STEP);
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    mem_req_q;
    logic [BIT_NUMBER-1:0]   mem_addr_q;
    logic [BIT_NUMBER-1:0]   fetch_pc_q;

    logic [BIT_NUMBER-1:0]   pc_mem_q  [FIFO_DEPTH];
    logic [BIT_NUMBER-1:0]   ins_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;

    logic                    push;
    logic                    pop;
    logic                    not_empty;
    logic                    has_room;
    logic [BIT_NUMBER-1:0]   next_addr;

    // Only a FETCH-state response is kept; DISCARD responses and responses
    // arriving with a branch belong to the abandoned path.
    assign push      = mem_req_q & mem_ready & (state_q == S_FETCH) & ~branch_taken;
    assign not_empty = (count_q != '0);
    assign pop       = not_empty & ~freeze;
    assign count_d   = branch_taken ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    assign has_room  = (count_d < DEPTH_C);
    assign next_addr = mem_addr_q + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (branch_taken) begin
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= branch_address;
                        fetch_pc_q <= branch_address;
                    end else if (has_room) begin
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                S_FETCH: begin
                    if (branch_taken) begin
                        fetch_pc_q <= branch_address;
                        if (mem_ready) begin
                            mem_addr_q <= branch_address;
                        end else begin
                            state_q <= S_DISCARD;
                        end
                    end else if (mem_ready) begin
                        fetch_pc_q <= next_addr;
                        if (has_room) begin
                            mem_addr_q <= next_addr;
                        end else begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    // Address stays on the bus until the stale response lands.
                    if (branch_taken) begin
                        fetch_pc_q <= branch_address;
                        if (mem_ready) begin
                            state_q    <= S_FETCH;
                            mem_addr_q <= branch_address;
                        end
                    end else if (mem_ready) begin
                        state_q    <= S_FETCH;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (branch_taken) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: it is only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= next_addr;
            ins_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign valid       = not_empty;
    assign pc          = not_empty ? pc_mem_q[rd_ptr_q]  : '0;
    assign instruction = not_empty ? ins_mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire
